// File: rtl/param_right_rotator_pipe.sv
// ---------------------------------------------------------------------------
// param_right_rotator_pipe
//   Pipelined right barrel rotator for a 2**N-bit word. Stage k rotates right
//   by 2**k when bit k of the carried amount is set, so a word crosses N
//   registered stages. All stages share one advance enable. A valid/ready
//   handshake on each side lets the block sit in a streaming datapath.
//
//   Optional feature macro: ROTR_BIDIR_EN
//     When defined, an in_dir port is added (1 = rotate left). A left rotate
//     by k is turned into a right rotate by (W-k) mod W before the stage 0
//     register, so the latency does not change.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous reset, active high
//   in_valid   in   1   in_data / in_amt (/ in_dir) valid
//   in_ready   out  1   block accepts a word this cycle
//   in_data    in   W   word to rotate
//   in_amt     in   N   rotate amount 0..W-1
//   in_dir     in   1   0 = right, 1 = left (only with ROTR_BIDIR_EN)
//   out_valid  out  1   out_data holds a result
//   out_ready  in   1   consumer takes out_data this cycle
//   out_data   out  W   rotated word
// ---------------------------------------------------------------------------
module param_right_rotator_pipe #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_data,
  input  logic [N-1:0]      in_amt,
`ifdef ROTR_BIDIR_EN
  input  logic              in_dir,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_data
);

  localparam int W = 2**N;

  // Right rotate by 2**k when sel is set; k is a loop constant so the
  // shift distances are fixed wiring per stage.
  function automatic logic [W-1:0] stage_rot(input logic [W-1:0] d,
                                             input logic         sel,
                                             input int           k);
    int s;
    s = 1 << k;
    if (sel) return (d >> s) | (d << (W - s));
    else     return d;
  endfunction

  logic [N-1:0] valid_q, valid_d;
  logic [W-1:0] data_q [N];
  logic [W-1:0] data_d [N];
  logic [N-1:0] amt_q  [N];
  logic [N-1:0] amt_d  [N];

  logic         adv;
  logic [N-1:0] amt_eff;

  // Direction decode: left by k == right by two's complement of k in N bits,
  // which leaves left-by-0 at 0.
`ifdef ROTR_BIDIR_EN
  always_comb begin
    amt_eff = in_dir ? (N'(0) - in_amt) : in_amt;
  end
`else
  always_comb begin
    amt_eff = in_amt;
  end
`endif

  always_comb begin
    adv = !valid_q[N-1] | out_ready;

    valid_d = valid_q;
    for (int k = 0; k < N; k++) begin
      data_d[k] = data_q[k];
      amt_d[k]  = amt_q[k];
    end

    if (adv) begin
      // Bubbles travel as valid=0 slots; their data is don't-care but still
      // loads so every stage has a single enable.
      valid_d[0] = in_valid;
      data_d[0]  = stage_rot(in_data, amt_eff[0], 0);
      amt_d[0]   = amt_eff;
      for (int k = 1; k < N; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = stage_rot(data_q[k-1], amt_q[k-1][k], k);
        amt_d[k]   = amt_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[N-1];
  assign out_data  = data_q[N-1];

endmodule

// File: tb/tb_param_right_rotator_pipe.sv
module tb_param_right_rotator_pipe;

  localparam int N = 3;
  localparam int W = 2**N;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] in_amt;
  logic         in_dir;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  param_right_rotator_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
`ifdef ROTR_BIDIR_EN
    .in_dir    (in_dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: rotate right one bit at a time, eff times.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input int a, input logic dir);
    int eff;
    logic [W-1:0] r;
    eff = a;
`ifdef ROTR_BIDIR_EN
    if (dir) eff = (W - a) % W;
`else
    if (dir) eff = a;
`endif
    r = d;
    repeat (eff) r = {r[0], r[W-1:1]};
    return r;
  endfunction

  // One clock: drive inputs, score transfers seen before the edge, advance.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [N-1:0] a,
                      input logic dir, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_dir    = dir;
    out_ready = ordy;
    #1;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("stream_data", {24'd0, out_data}, {24'd0, exp_q[0]});
          obs_log.push_back(out_data);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_rot(d, int'(a), dir));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      budget++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    // let the last transfer leave the output register
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drain_outv", {31'd0, out_valid}, 32'd0);
  endtask

  // Single word into an empty pipe: check latency and the constant result.
  task automatic single(input string tag, input logic [W-1:0] d, input logic [N-1:0] a,
                        input logic dir, input logic [W-1:0] expv);
    int cnt;
    step(1'b1, d, a, dir, 1'b1);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      cnt++;
    end
    chk({tag, "_lat"}, cnt, N);
    chk(tag, {24'd0, out_data}, {24'd0, expv});
    drain();
  endtask

  initial begin
    logic [W-1:0] a5_exp [8];
    logic [W-1:0] held;
    int n_in;

    a5_exp = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};

    // Reset held 2 cycles with in_valid=1
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd2; in_dir = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_outv", {31'd0, out_valid}, 32'd0);
      chk("rst_outd", {24'd0, out_data}, 32'd0);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);

    // Directed single words (latency + value)
    single("r1",  8'b1000_0001, 3'd1, 1'b0, 8'b1100_0000);
    single("r0",  8'b1000_0001, 3'd0, 1'b0, 8'b1000_0001);
    single("r7",  8'b1000_0001, 3'd7, 1'b0, 8'b0000_0011);

    // Eight back-to-back words, A5 rotated by 0..7
    obs_log.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 8'hA5, N'(i), 1'b0, 1'b1);
    drain();
    chk("a5_count", obs_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < obs_log.size(); i++)
      chk($sformatf("a5_%0d", i), {24'd0, obs_log[i]}, {24'd0, a5_exp[i]});

    // Backpressure with a full pipe
    n_in = 0;
    while (!out_valid && n_in < 10) begin
      step(1'b1, W'($urandom), N'($urandom), 1'b0, 1'b1);
      n_in++;
    end
    chk("bp_fill", n_in, N);
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, W'($urandom), N'($urandom), 1'b0, 1'b0);
      chk("bp_inrdy", {31'd0, in_ready}, 32'd0);
      chk("bp_outv",  {31'd0, out_valid}, 32'd1);
      chk("bp_hold",  {24'd0, out_data}, {24'd0, held});
    end
    for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), N'($urandom), 1'b0, 1'b1);
    drain();

    // Reset with 3 words in flight
    for (int i = 0; i < 3; i++) step(1'b1, 8'hF0 + W'(i), N'(i + 1), 1'b0, 1'b0);
    chk("mid_full", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_outv", {31'd0, out_valid}, 32'd0);
    chk("mid_outd", {24'd0, out_data}, 32'd0);
    exp_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      chk("mid_quiet", {31'd0, out_valid}, 32'd0);
    end
    single("mid_fresh", 8'b0001_0110, 3'd2, 1'b0, 8'b1000_0101);

`ifdef ROTR_BIDIR_EN
    single("l1", 8'b1000_0001, 3'd1, 1'b1, 8'b0000_0011);
    single("l0", 8'b1000_0001, 3'd0, 1'b1, 8'b1000_0001);
`endif

    // Random traffic with random stalls and bubbles
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), N'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
